// File: rtl/dma_line_engine.sv
// Bidirectional line DMA: moves LINE_W host lines to/from a WORD_W memory port,
// WORDS consecutive word accesses per line, with progress and done reporting.
module dma_line_engine #(
    parameter int unsigned LINE_W = 512,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic              cfg_dir,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [CNT_W-1:0]  cfg_lines,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  lines_done,
    input  logic              h2m_empty,
    input  logic [LINE_W-1:0] h2m_data,
    output logic              h2m_rd_en,
    input  logic              m2h_full,
    output logic [LINE_W-1:0] m2h_data,
    output logic              m2h_wr_en,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int unsigned WORDS = LINE_W / WORD_W;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_W / 8);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StH2mLoad,
        StH2mWr,
        StM2hRd,
        StM2hWait,
        StM2hPush,
        StDone
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  lines_q;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] line_q;
    logic [RD_LAT-1:0] rd_vld_q;
    logic [IDX_W-1:0]  rd_idx_q [RD_LAT];

    logic [CNT_W-1:0]  lines_inc;
    logic              last_line;
    logic [IDX_W-1:0]  idx_inc;
    logic              ret_vld;
    logic [IDX_W-1:0]  ret_idx;

    assign lines_inc = lines_done + CNT_W'(1);
    assign last_line = (lines_inc == lines_q);
    assign idx_inc   = idx_q + IDX_W'(1);
    assign ret_vld   = rd_vld_q[RD_LAT-1];
    assign ret_idx   = rd_idx_q[RD_LAT-1];
    assign busy      = (state_q != StIdle);
    assign m2h_data  = line_q;

    // idx_q always names the word currently on the memory bus; addr_q is the next address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lines_q    <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            line_q     <= '0;
            rd_vld_q   <= '0;
            for (int k = 0; k < RD_LAT; k++) rd_idx_q[k] <= '0;
            lines_done <= '0;
            done       <= 1'b0;
            h2m_rd_en  <= 1'b0;
            m2h_wr_en  <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            h2m_rd_en <= 1'b0;
            m2h_wr_en <= 1'b0;
            done      <= 1'b0;
            if (cfg_abort) begin
                state_q  <= StIdle;
                mem_en   <= 1'b0;
                mem_we   <= 1'b0;
                rd_vld_q <= '0;
            end else begin
                rd_vld_q[0] <= mem_en & ~mem_we;
                rd_idx_q[0] <= idx_q;
                for (int k = 1; k < RD_LAT; k++) begin
                    rd_vld_q[k] <= rd_vld_q[k-1];
                    rd_idx_q[k] <= rd_idx_q[k-1];
                end
                if (ret_vld) line_q[int'(ret_idx)*WORD_W +: WORD_W] <= mem_rdata;

                case (state_q)
                    StIdle: begin
                        if (cfg_start) begin
                            lines_q    <= cfg_lines;
                            lines_done <= '0;
                            addr_q     <= cfg_base;
                            idx_q      <= '0;
                            if (cfg_lines == '0) begin
                                state_q <= StDone;
                                done    <= 1'b1;
                            end else if (!cfg_dir) begin
                                state_q <= StH2mLoad;
                            end else begin
                                state_q  <= StM2hRd;
                                mem_en   <= 1'b1;
                                mem_we   <= 1'b0;
                                mem_addr <= cfg_base;
                                addr_q   <= cfg_base + STRIDE;
                            end
                        end
                    end
                    StH2mLoad: begin
                        if (!h2m_empty) begin
                            line_q    <= h2m_data;
                            h2m_rd_en <= 1'b1;
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_q;
                            mem_wdata <= h2m_data[WORD_W-1:0];
                            addr_q    <= addr_q + STRIDE;
                            idx_q     <= '0;
                            state_q   <= StH2mWr;
                        end
                    end
                    StH2mWr: begin
                        if (idx_q == LAST_IDX) begin
                            mem_en     <= 1'b0;
                            mem_we     <= 1'b0;
                            lines_done <= lines_inc;
                            if (last_line) begin
                                state_q <= StDone;
                                done    <= 1'b1;
                            end else begin
                                state_q <= StH2mLoad;
                            end
                        end else begin
                            idx_q     <= idx_inc;
                            mem_addr  <= addr_q;
                            mem_wdata <= line_q[int'(idx_inc)*WORD_W +: WORD_W];
                            addr_q    <= addr_q + STRIDE;
                        end
                    end
                    StM2hRd: begin
                        if (idx_q == LAST_IDX) begin
                            mem_en  <= 1'b0;
                            state_q <= StM2hWait;
                        end else begin
                            idx_q    <= idx_inc;
                            mem_addr <= addr_q;
                            addr_q   <= addr_q + STRIDE;
                        end
                    end
                    StM2hWait: begin
                        // Returns arrive in issue order, so the last index closes the line.
                        if (ret_vld && ret_idx == LAST_IDX) state_q <= StM2hPush;
                    end
                    StM2hPush: begin
                        if (!m2h_full) begin
                            m2h_wr_en  <= 1'b1;
                            lines_done <= lines_inc;
                            if (last_line) begin
                                state_q <= StDone;
                                done    <= 1'b1;
                            end else begin
                                state_q  <= StM2hRd;
                                idx_q    <= '0;
                                mem_en   <= 1'b1;
                                mem_we   <= 1'b0;
                                mem_addr <= addr_q;
                                addr_q   <= addr_q + STRIDE;
                            end
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_line_engine.sv
// Scoreboard bench for dma_line_engine: expected memory accesses and pushed lines are
// queued when a transfer is set up and popped as the DUT produces them.
module tb_dma_line_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_start, cfg_abort, cfg_dir;
    logic [31:0]  cfg_base;
    logic [15:0]  cfg_lines;
    logic         busy, done;
    logic [15:0]  lines_done;
    logic         h2m_empty;
    logic [511:0] h2m_data;
    logic         h2m_rd_en;
    logic         m2h_full;
    logic [511:0] m2h_data;
    logic         m2h_wr_en;
    logic         mem_en, mem_we;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dma_line_engine #(
        .LINE_W(512), .WORD_W(32), .ADDR_W(32), .CNT_W(16), .RD_LAT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_dir(cfg_dir),
        .cfg_base(cfg_base), .cfg_lines(cfg_lines),
        .busy(busy), .done(done), .lines_done(lines_done),
        .h2m_empty(h2m_empty), .h2m_data(h2m_data), .h2m_rd_en(h2m_rd_en),
        .m2h_full(m2h_full), .m2h_data(m2h_data), .m2h_wr_en(m2h_wr_en),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: read data equals the read address, two cycles after issue.
    logic [31:0] rd_p1 = 32'h0;
    logic [31:0] rd_p2 = 32'h0;
    always @(posedge clk) begin
        rd_p1 <= (mem_en && !mem_we) ? mem_addr : 32'h0;
        rd_p2 <= rd_p1;
    end
    assign mem_rdata = rd_p2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t         acc_q[$];
    logic [511:0] line_exp_q[$];
    logic [511:0] h2m_fifo[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cnt, rd_en_cnt, wr_en_cnt, done_cnt, last_mem_cyc, done_cyc;

    task automatic fifo_refresh();
        h2m_empty = (h2m_fifo.size() == 0);
        h2m_data  = (h2m_fifo.size() != 0) ? h2m_fifo[0] : 512'h0;
    endtask

    task automatic clear_counts();
        acc_cnt = 0; rd_en_cnt = 0; wr_en_cnt = 0; done_cnt = 0;
        last_mem_cyc = -1; done_cyc = -1;
    endtask

    // One clock: sample at the falling edge, consume scoreboards, service the host FIFO.
    task automatic step();
        acc_t         e;
        logic [511:0] el;
        @(negedge clk);
        cyc++;
        if (mem_en === 1'b1) begin
            acc_cnt++;
            last_mem_cyc = cyc;
            n_checks++;
            if (acc_q.size() == 0) begin
                n_fail++;
                $display("FAIL mem_access: got we=%0b addr=%h wdata=%h, required no access",
                         mem_we, mem_addr, mem_wdata);
            end else begin
                e = acc_q.pop_front();
                if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
                    n_fail++;
                    $display("FAIL mem_access: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                             mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
                end
            end
        end
        if (m2h_wr_en === 1'b1) begin
            wr_en_cnt++;
            n_checks++;
            if (line_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL m2h_push: got push of %h, required no push", m2h_data);
            end else begin
                el = line_exp_q.pop_front();
                if (m2h_data !== el) begin
                    n_fail++;
                    $display("FAIL m2h_line: got %h required %h", m2h_data, el);
                end
            end
        end
        if (h2m_rd_en === 1'b1) begin
            rd_en_cnt++;
            if (h2m_fifo.size() != 0) void'(h2m_fifo.pop_front());
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        fifo_refresh();
    endtask

    task automatic start_xfer(input logic dir, input logic [31:0] base, input logic [15:0] lines);
        cfg_dir = dir; cfg_base = base; cfg_lines = lines; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic push_writes(input logic [31:0] base, input int n, input logic [511:0] line);
        for (int i = 0; i < 16; i++)
            acc_q.push_back('{we: 1'b1, addr: base + 32'((n * 16 + i) * 4), data: line[i*32 +: 32]});
    endtask

    task automatic push_m2h_line(input logic [31:0] base, input int n, input bit expect_push);
        logic [511:0] l;
        logic [31:0]  a;
        for (int i = 0; i < 16; i++) begin
            a = base + 32'((n * 16 + i) * 4);
            acc_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
            l[i*32 +: 32] = a;
        end
        if (expect_push) line_exp_q.push_back(l);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) step();
        n_checks++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL done_timeout: got no done in %0d cycles, required a done pulse", budget);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, h2m_rd_en, m2h_wr_en, mem_en, mem_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b required 000000",
                     {busy, done, h2m_rd_en, m2h_wr_en, mem_en, mem_we});
        end
        n_checks++;
        if (lines_done !== 16'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got lines_done=%h addr=%h wdata=%h, required all 0",
                     lines_done, mem_addr, mem_wdata);
        end
        n_checks++;
        if (m2h_data !== 512'h0) begin
            n_fail++;
            $display("FAIL reset_line: got %h required 0", m2h_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_h2m_single();
        logic [511:0] l;
        clear_counts();
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = 32'hA0 + 32'(i);
        h2m_fifo.push_back(l);
        push_writes(32'h5000, 0, l);
        fifo_refresh();
        start_xfer(1'b0, 32'h5000, 16'd1);
        wait_done(100);
        n_checks++;
        if (acc_cnt != 16 || acc_q.size() != 0) begin
            n_fail++;
            $display("FAIL h2m_writes: got %0d writes (%0d left), required 16 (0 left)",
                     acc_cnt, acc_q.size());
        end
        n_checks++;
        if (rd_en_cnt != 1) begin
            n_fail++;
            $display("FAIL h2m_rd_en: got %0d pops required 1", rd_en_cnt);
        end
        n_checks++;
        if (done_cyc != last_mem_cyc + 1) begin
            n_fail++;
            $display("FAIL h2m_done_timing: got done at %0d, required %0d", done_cyc, last_mem_cyc + 1);
        end
        n_checks++;
        if (lines_done !== 16'd1) begin
            n_fail++;
            $display("FAIL h2m_lines_done: got %0d required 1", lines_done);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL h2m_idle_after: got done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_m2h_backpressure();
        clear_counts();
        push_m2h_line(32'h6000, 0, 1'b1);
        push_m2h_line(32'h6000, 1, 1'b1);
        start_xfer(1'b1, 32'h6000, 16'd2);
        for (int i = 0; i < 100 && wr_en_cnt == 0; i++) step();
        n_checks++;
        if (wr_en_cnt != 1) begin
            n_fail++;
            $display("FAIL m2h_first_push: got %0d pushes required 1", wr_en_cnt);
        end
        m2h_full = 1'b1;
        repeat (26) step();
        n_checks++;
        if (wr_en_cnt != 1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL m2h_full_hold: got pushes=%0d busy=%b required 1 1", wr_en_cnt, busy);
        end
        m2h_full = 1'b0;
        wait_done(60);
        n_checks++;
        if (wr_en_cnt != 2 || lines_done !== 16'd2) begin
            n_fail++;
            $display("FAIL m2h_complete: got pushes=%0d lines_done=%0d required 2 2",
                     wr_en_cnt, lines_done);
        end
        n_checks++;
        if (acc_q.size() != 0 || line_exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL m2h_leftover: got %0d reads %0d lines outstanding, required 0 0",
                     acc_q.size(), line_exp_q.size());
        end
        step();
    endtask

    task automatic test_h2m_stall();
        logic [511:0] l0, l1;
        clear_counts();
        l0 = rand_line();
        l1 = rand_line();
        push_writes(32'h7000, 0, l0);
        push_writes(32'h7000, 1, l1);
        h2m_fifo.push_back(l0);
        fifo_refresh();
        start_xfer(1'b0, 32'h7000, 16'd2);
        for (int i = 0; i < 60 && acc_cnt < 16; i++) step();
        repeat (10) step();
        n_checks++;
        if (acc_cnt != 16 || busy !== 1'b1 || lines_done !== 16'd1) begin
            n_fail++;
            $display("FAIL h2m_stall: got writes=%0d busy=%b lines_done=%0d required 16 1 1",
                     acc_cnt, busy, lines_done);
        end
        h2m_fifo.push_back(l1);
        fifo_refresh();
        wait_done(60);
        n_checks++;
        if (acc_cnt != 32 || acc_q.size() != 0 || rd_en_cnt != 2 || lines_done !== 16'd2) begin
            n_fail++;
            $display("FAIL h2m_resume: got writes=%0d left=%0d pops=%0d lines_done=%0d, required 32 0 2 2",
                     acc_cnt, acc_q.size(), rd_en_cnt, lines_done);
        end
        step();
    endtask

    task automatic test_wrap();
        logic [511:0] l;
        clear_counts();
        l = rand_line();
        push_writes(32'hFFFF_FFF0, 0, l);
        h2m_fifo.push_back(l);
        fifo_refresh();
        start_xfer(1'b0, 32'hFFFF_FFF0, 16'd1);
        wait_done(60);
        n_checks++;
        if (acc_cnt != 16 || acc_q.size() != 0 || lines_done !== 16'd1) begin
            n_fail++;
            $display("FAIL wrap: got writes=%0d left=%0d lines_done=%0d, required 16 0 1",
                     acc_cnt, acc_q.size(), lines_done);
        end
        step();
    endtask

    task automatic test_zero_and_busy();
        clear_counts();
        start_xfer(1'b0, 32'h1234, 16'd0);
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL zero_done: got %0d done pulses one cycle after start, required 1", done_cnt);
        end
        repeat (3) step();
        n_checks++;
        if (acc_cnt != 0 || rd_en_cnt != 0 || wr_en_cnt != 0 || done_cnt != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_strobes: got mem=%0d pop=%0d push=%0d done=%0d busy=%b, required 0 0 0 1 0",
                     acc_cnt, rd_en_cnt, wr_en_cnt, done_cnt, busy);
        end
        clear_counts();
        push_m2h_line(32'h8000, 0, 1'b1);
        start_xfer(1'b1, 32'h8000, 16'd1);
        repeat (3) step();
        start_xfer(1'b0, 32'hDEAD_0000, 16'd5);
        wait_done(60);
        n_checks++;
        if (acc_cnt != 16 || wr_en_cnt != 1 || lines_done !== 16'd1 || acc_q.size() != 0) begin
            n_fail++;
            $display("FAIL busy_start: got reads=%0d pushes=%0d lines_done=%0d left=%0d, required 16 1 1 0",
                     acc_cnt, wr_en_cnt, lines_done, acc_q.size());
        end
        step();
    endtask

    task automatic test_abort_and_reset();
        logic [511:0] l;
        clear_counts();
        push_m2h_line(32'h9000, 0, 1'b1);
        push_m2h_line(32'h9000, 1, 1'b0);
        start_xfer(1'b1, 32'h9000, 16'd2);
        for (int i = 0; i < 100 && wr_en_cnt == 0; i++) step();
        for (int i = 0; i < 30 && mem_en === 1'b1; i++) step();
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b required 0", busy);
        end
        repeat (10) step();
        n_checks++;
        if (done_cnt != 0 || wr_en_cnt != 1 || acc_cnt != 32 || lines_done !== 16'd1) begin
            n_fail++;
            $display("FAIL abort_quiet: got done=%0d pushes=%0d reads=%0d lines_done=%0d, required 0 1 32 1",
                     done_cnt, wr_en_cnt, acc_cnt, lines_done);
        end
        cfg_dir = 1'b1; cfg_base = 32'h0; cfg_lines = 16'd1;
        cfg_start = 1'b1; cfg_abort = 1'b1;
        step();
        cfg_start = 1'b0; cfg_abort = 1'b0;
        repeat (3) step();
        n_checks++;
        if (busy !== 1'b0 || acc_cnt != 32 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL start_abort_idle: got busy=%b reads=%0d done=%0d, required 0 32 0",
                     busy, acc_cnt, done_cnt);
        end

        clear_counts();
        l = rand_line();
        h2m_fifo.push_back(l);
        push_writes(32'hA000, 0, l);
        fifo_refresh();
        start_xfer(1'b0, 32'hA000, 16'd1);
        for (int i = 0; i < 40 && acc_cnt < 5; i++) step();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_en !== 1'b0 || busy !== 1'b0 || h2m_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_wr: got mem_en=%b busy=%b rd_en=%b required 0 0 0",
                     mem_en, busy, h2m_rd_en);
        end
        acc_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        n_checks++;
        if (acc_cnt != 5 || done_cnt != 0 || lines_done !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_quiet: got writes=%0d done=%0d lines_done=%0d busy=%b, required 5 0 0 0",
                     acc_cnt, done_cnt, lines_done, busy);
        end

        clear_counts();
        l = rand_line();
        h2m_fifo.push_back(l);
        push_writes(32'hB000, 0, l);
        fifo_refresh();
        start_xfer(1'b0, 32'hB000, 16'd1);
        wait_done(60);
        n_checks++;
        if (acc_cnt != 16 || acc_q.size() != 0 || lines_done !== 16'd1) begin
            n_fail++;
            $display("FAIL after_reset_xfer: got writes=%0d left=%0d lines_done=%0d, required 16 0 1",
                     acc_cnt, acc_q.size(), lines_done);
        end
        step();
    endtask

    initial begin
        cfg_start = 1'b0; cfg_abort = 1'b0; cfg_dir = 1'b0;
        cfg_base = 32'h0; cfg_lines = 16'h0; m2h_full = 1'b0;
        h2m_empty = 1'b1; h2m_data = 512'h0;
        clear_counts();
        test_reset();
        test_h2m_single();
        test_m2h_backpressure();
        test_h2m_stall();
        test_wrap();
        test_zero_and_busy();
        test_abort_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
